// File: rtl/ga_pkg.sv
// ga_pkg
// Shared definitions for the GA run controller slice.
//   ga_state_e          : run-controller FSM state encoding
//   ERROR_WIDTH_DEFAULT : default width of GA error/fitness values
package ga_pkg;

    localparam int unsigned ERROR_WIDTH_DEFAULT = 9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GA_RESET = 3'd1,
        S_RUN      = 3'd2,
        S_RESEED   = 3'd3,
        S_DONE     = 3'd4
    } ga_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : clear to zero (wins over inc_i)
//   inc_i        : increment by one, holding at all-ones
//   count_o      : registered count
//   count_inc_o  : value the counter would take on an increment
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o,
    output logic [Width-1:0] count_inc_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_inc_s;

    // Saturating successor of the current count.
    always_comb begin
        count_inc_s = count_q;
        if (count_q == {Width{1'b1}}) begin
            count_inc_s = count_q;
        end else begin
            count_inc_s = count_q + Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_inc_s;
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o     = count_q;
    assign count_inc_o = count_inc_s;

endmodule

// File: rtl/ga_run_controller.sv
// ga_run_controller
// Sequences one GA run: resets the GA datapath, lets it run generation by
// generation, tracks the best error, reseeds on stagnation and stops when
// solved, when the generation limit is hit, or on abort.
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : run request / stop request
//   targetError         : solved when GA error <= this
//   maxGenerations      : generation limit (0 = unlimited)
//   stallLimit          : non-improving generations before reseed (0 = never)
//   genDone, gaBestError: end-of-generation pulse and its best error
//   gaRst, gaCe, reseed : GA datapath controls
//   busy, done, solved  : run status
//   generation, bestError : completed generations / lowest error this run
module ga_run_controller
    import ga_pkg::*;
#(
    parameter int unsigned ErrorWidth      = ERROR_WIDTH_DEFAULT,
    parameter int unsigned GenerationWidth = 16,
    parameter int unsigned StallWidth      = 8,
    parameter int unsigned ResetCycles     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ErrorWidth-1:0]      targetError,
    input  logic [GenerationWidth-1:0] maxGenerations,
    input  logic [StallWidth-1:0]      stallLimit,
    input  logic                       genDone,
    input  logic [ErrorWidth-1:0]      gaBestError,
    output logic                       gaRst,
    output logic                       gaCe,
    output logic                       reseed,
    output logic                       busy,
    output logic                       done,
    output logic                       solved,
    output logic [GenerationWidth-1:0] generation,
    output logic [ErrorWidth-1:0]      bestError
);

    localparam int unsigned RcWidth = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
    localparam logic [RcWidth-1:0] RcLast = RcWidth'(ResetCycles - 1);

    ga_state_e                  state_q;
    logic [RcWidth-1:0]         rc_q;
    logic                       ga_rst_q, ga_ce_q, reseed_q, busy_q, done_q, solved_q;
    logic [ErrorWidth-1:0]      best_error_q;
    logic [GenerationWidth-1:0] gen_q, gen_d;
    logic [StallWidth-1:0]      stall_q, stall_inc_s, stall_d;
    logic                       start_ok_s, run_step_s, improved_s;
    logic                       stall_clr_s, stall_inc_en_s;

    // Counter controls and the post-generation counts used by the exit tests.
    always_comb begin
        start_ok_s     = 1'b0;
        run_step_s     = 1'b0;
        improved_s     = (gaBestError < best_error_q);
        stall_d        = stall_inc_s;
        stall_clr_s    = 1'b0;
        stall_inc_en_s = 1'b0;
        if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end
        // abort beats genDone, so an aborted generation is not counted
        if ((state_q == S_RUN) && genDone && !abort) begin
            run_step_s = 1'b1;
        end else begin
            run_step_s = 1'b0;
        end
        if (improved_s) begin
            stall_d = '0;
        end else begin
            stall_d = stall_inc_s;
        end
        stall_clr_s    = start_ok_s || (state_q == S_RESEED) || (run_step_s && improved_s);
        stall_inc_en_s = run_step_s && !improved_s;
    end

    sat_counter #(.Width(GenerationWidth)) u_gen_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (start_ok_s),
        .inc_i       (run_step_s),
        .count_o     (gen_q),
        .count_inc_o (gen_d)
    );

    sat_counter #(.Width(StallWidth)) u_stall_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (stall_clr_s),
        .inc_i       (stall_inc_en_s),
        .count_o     (stall_q),
        .count_inc_o (stall_inc_s)
    );

    // Run FSM with registered GA controls and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rc_q         <= '0;
            ga_rst_q     <= 1'b1;
            ga_ce_q      <= 1'b0;
            reseed_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            solved_q     <= 1'b0;
            best_error_q <= '1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_GA_RESET;
                        rc_q         <= '0;
                        ga_rst_q     <= 1'b1;
                        ga_ce_q      <= 1'b0;
                        reseed_q     <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        solved_q     <= 1'b0;
                        best_error_q <= '1;
                    end
                end
                S_GA_RESET: begin
                    if (abort) begin
                        state_q  <= S_DONE;
                        ga_rst_q <= 1'b0;
                        ga_ce_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        solved_q <= 1'b0;
                    end else if (rc_q == RcLast) begin
                        state_q  <= S_RUN;
                        ga_rst_q <= 1'b0;
                        ga_ce_q  <= 1'b1;
                    end else begin
                        rc_q <= rc_q + RcWidth'(1);
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q  <= S_DONE;
                        ga_ce_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        solved_q <= 1'b0;
                    end else if (genDone) begin
                        if (improved_s) begin
                            best_error_q <= gaBestError;
                        end
                        // exit priority: solved, then generation limit, then stall
                        if (gaBestError <= targetError) begin
                            state_q  <= S_DONE;
                            ga_ce_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            solved_q <= 1'b1;
                        end else if ((maxGenerations != '0) && (gen_d == maxGenerations)) begin
                            state_q  <= S_DONE;
                            ga_ce_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            solved_q <= 1'b0;
                        end else if ((stallLimit != '0) && (stall_d == stallLimit)) begin
                            state_q  <= S_RESEED;
                            ga_ce_q  <= 1'b0;
                            reseed_q <= 1'b1;
                        end
                    end
                end
                S_RESEED: begin
                    reseed_q <= 1'b0;
                    if (abort) begin
                        state_q  <= S_DONE;
                        ga_ce_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        solved_q <= 1'b0;
                    end else begin
                        state_q <= S_RUN;
                        ga_ce_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    rc_q         <= '0;
                    ga_rst_q     <= 1'b1;
                    ga_ce_q      <= 1'b0;
                    reseed_q     <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    solved_q     <= 1'b0;
                    best_error_q <= '1;
                end
            endcase
        end
    end

    assign gaRst      = ga_rst_q;
    assign gaCe       = ga_ce_q;
    assign reseed     = reseed_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign solved     = solved_q;
    assign generation = gen_q;
    assign bestError  = best_error_q;

endmodule

// File: tb/tb_ga_run_controller.sv
// tb_ga_run_controller
// Directed scenarios followed by randomized traffic, every cycle compared
// against a phase-level reference model of the run controller.
module tb_ga_run_controller;

    localparam int EW = 9;
    localparam int GW = 16;
    localparam int SW = 8;
    localparam int RC = 4;
    localparam int GEN_MAX   = (1 << GW) - 1;
    localparam int BEST_MAX  = (1 << EW) - 1;
    localparam int STALL_MAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst, start, abort, genDone;
    logic [EW-1:0] targetError, gaBestError;
    logic [GW-1:0] maxGenerations;
    logic [SW-1:0] stallLimit;
    logic          gaRst, gaCe, reseed, busy, done, solved;
    logic [GW-1:0] generation;
    logic [EW-1:0] bestError;

    always #5 clk = ~clk;

    ga_run_controller #(
        .ErrorWidth(EW), .GenerationWidth(GW), .StallWidth(SW), .ResetCycles(RC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .targetError(targetError), .maxGenerations(maxGenerations),
        .stallLimit(stallLimit), .genDone(genDone), .gaBestError(gaBestError),
        .gaRst(gaRst), .gaCe(gaCe), .reseed(reseed), .busy(busy),
        .done(done), .solved(solved), .generation(generation), .bestError(bestError)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which phase the run is in plus the run statistics.
    int m_reset_left;
    bit m_idle, m_run, m_reseed, m_done, m_solved;
    int m_gen, m_best, m_stall;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step();
        bit m_busy;
        m_busy = (m_reset_left > 0) || m_run || m_reseed;
        if (rst) begin
            m_idle = 1; m_reset_left = 0; m_run = 0; m_reseed = 0;
            m_done = 0; m_solved = 0; m_gen = 0; m_best = BEST_MAX; m_stall = 0;
        end else if ((m_idle || m_done) && start) begin
            m_idle = 0; m_done = 0; m_solved = 0; m_reset_left = RC;
            m_gen = 0; m_stall = 0; m_best = BEST_MAX;
        end else if (m_busy && abort) begin
            m_reset_left = 0; m_run = 0; m_reseed = 0; m_done = 1; m_solved = 0;
        end else if (m_reset_left > 0) begin
            m_reset_left--;
            if (m_reset_left == 0) m_run = 1;
        end else if (m_reseed) begin
            m_reseed = 0; m_stall = 0; m_run = 1;
        end else if (m_run && genDone) begin
            if (m_gen < GEN_MAX) m_gen++;
            if (int'(gaBestError) < m_best) begin
                m_best = int'(gaBestError); m_stall = 0;
            end else if (m_stall < STALL_MAX) begin
                m_stall++;
            end
            if (gaBestError <= targetError) begin
                m_run = 0; m_done = 1; m_solved = 1;
            end else if (maxGenerations != 0 && m_gen == int'(maxGenerations)) begin
                m_run = 0; m_done = 1; m_solved = 0;
            end else if (stallLimit != 0 && m_stall == int'(stallLimit)) begin
                m_run = 0; m_reseed = 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("gaRst",      32'(gaRst),      32'(m_idle || (m_reset_left > 0)));
        check_eq("gaCe",       32'(gaCe),       32'(m_run));
        check_eq("reseed",     32'(reseed),     32'(m_reseed));
        check_eq("busy",       32'(busy),       32'((m_reset_left > 0) || m_run || m_reseed));
        check_eq("done",       32'(done),       32'(m_done));
        check_eq("solved",     32'(solved),     32'(m_solved));
        check_eq("generation", 32'(generation), m_gen);
        check_eq("bestError",  32'(bestError),  m_best);
    endtask

    // One clock: apply inputs, step the model at the edge, compare 1 ns later.
    task automatic cyc(input bit r, input bit s, input bit a, input bit g, input int e);
        rst = r; start = s; abort = a; genDone = g; gaBestError = EW'(e);
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_reset();
        for (int i = 0; i < RC; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int n_rst_hi;
        m_idle = 1; m_reset_left = 0; m_run = 0; m_reseed = 0;
        m_done = 0; m_solved = 0; m_gen = 0; m_best = BEST_MAX; m_stall = 0;
        targetError = '0; maxGenerations = '0; stallLimit = '0;

        // reset state
        cyc(1, 0, 0, 0, 0);
        check_eq("rst_gaRst", 32'(gaRst), 32'd1);
        check_eq("rst_best",  32'(bestError), 32'd511);
        cyc(0, 0, 1, 1, 0);   // abort and genDone in IDLE are ignored
        check_eq("idle_hold_gaRst", 32'(gaRst), 32'd1);

        // errors 5,3,0 with target 0 -> solved at generation 3
        cyc(0, 1, 0, 0, 0);
        wait_reset();
        cyc(0, 0, 0, 1, 5); cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3); cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check_eq("s1_solved", 32'(solved), 32'd1);
        check_eq("s1_gen",    32'(generation), 32'd3);
        check_eq("s1_best",   32'(bestError), 32'd0);

        // restart from DONE: gaRst high exactly RC cycles, then gaCe
        maxGenerations = 16'd4;
        n_rst_hi = 0;
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            if (gaCe) break;
            if (gaRst) n_rst_hi++;
            cyc(0, 0, 0, 0, 0);
        end
        check_eq("rst_len", 32'(n_rst_hi), 32'(RC));
        check_eq("rst_then_ce", 32'(gaCe), 32'd1);

        // limit of 4 generations, all errors 7 -> unsolved stop
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 7);
        check_eq("s2_done",   32'(done), 32'd1);
        check_eq("s2_solved", 32'(solved), 32'd0);
        check_eq("s2_gen",    32'(generation), 32'd4);

        // stall limit 2, errors 6,6,6 -> reseed after the second repeat
        maxGenerations = 16'd0; stallLimit = 8'd2;
        cyc(0, 1, 1, 0, 0);   // start wins over abort in DONE
        wait_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 6);
        check_eq("s3_reseed", 32'(reseed), 32'd1);
        check_eq("s3_best",   32'(bestError), 32'd6);
        check_eq("s3_gen",    32'(generation), 32'd3);
        cyc(0, 0, 0, 1, 0);   // genDone during RESEED is ignored
        check_eq("s3_reseed_end", 32'(reseed), 32'd0);
        check_eq("s3_gen_hold",   32'(generation), 32'd3);
        cyc(0, 0, 0, 1, 6);
        check_eq("s3_gen4", 32'(generation), 32'd4);

        // abort with a solving genDone -> unsolved, generation unchanged
        cyc(0, 0, 1, 1, 0);
        check_eq("s4_done",   32'(done), 32'd1);
        check_eq("s4_solved", 32'(solved), 32'd0);
        check_eq("s4_gen",    32'(generation), 32'd4);

        // error equal to target on the last allowed generation -> solved
        maxGenerations = 16'd2; stallLimit = 8'd0; targetError = 9'd3;
        cyc(0, 1, 0, 0, 0);
        wait_reset();
        cyc(0, 0, 0, 1, 9);
        cyc(0, 0, 0, 1, 3);
        check_eq("s5_solved", 32'(solved), 32'd1);
        check_eq("s5_gen",    32'(generation), 32'd2);

        // rst in RUN overrides start and genDone
        maxGenerations = 16'd0;
        cyc(0, 1, 0, 0, 0);
        wait_reset();
        cyc(0, 0, 0, 1, 5);
        cyc(1, 1, 0, 1, 0);
        check_eq("s6_gaRst", 32'(gaRst), 32'd1);
        check_eq("s6_busy",  32'(busy), 32'd0);
        check_eq("s6_gen",   32'(generation), 32'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 60 == 0) begin
                targetError    = EW'($urandom_range(0, 4));
                maxGenerations = GW'($urandom_range(0, 8));
                stallLimit     = SW'($urandom_range(0, 3));
            end
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 20)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
